// File: rtl/apb_regfile_slave.sv
// APB3 completer with six RW scratch registers, a read-only write counter
// and a read-only ID register. Adds WAIT_CYCLES wait states per transfer
// and answers illegal accesses with PSLVERR. All bus outputs are registered.
// ADDR_W must be at least 6 so the upper-address check has bits to look at.
module apb_regfile_slave #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic              pwrite_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [31:0]       ctrl_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned NUM_RW    = 6;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic        write_reg, write_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        err_reg, err_next;
  logic        pready_reg, pready_next;
  logic        pslverr_reg, pslverr_next;
  logic [31:0] prdata_reg, prdata_next;
  logic [31:0] regs_reg [NUM_RW];
  logic [31:0] wr_count_reg;
  logic        commit;
  logic [NUM_RW-1:0] reg_wen;

  // Setup-phase decode taken straight from the bus
  logic [2:0] setup_idx;
  logic       upper_bad;
  logic       setup_err;

  assign setup_idx = paddr_i[4:2];
  assign upper_bad = |paddr_i[ADDR_W-1:5];
  assign setup_err = (paddr_i[1:0] != 2'b00) | upper_bad |
                     (pwrite_i & (setup_idx >= 3'd6));

  // Register-file read mux; WR_COUNT is sampled before any write of this transfer
  function automatic logic [31:0] read_mux(input logic [2:0] idx);
    logic [31:0] val;
    val = 32'd0;
    case (idx)
      3'd6:    val = wr_count_reg;
      3'd7:    val = ID_VALUE;
      default: val = regs_reg[idx];
    endcase
    return val;
  endfunction

  // Next-state and registered-output logic of the transfer FSM
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    write_next   = write_reg;
    wdata_next   = wdata_reg;
    err_next     = err_reg;
    pready_next  = pready_reg;
    pslverr_next = pslverr_reg;
    prdata_next  = prdata_reg;
    commit       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A bare access phase (penable without setup) is ignored here
        if (psel_i && !penable_i) begin
          idx_next   = setup_idx;
          write_next = pwrite_i;
          wdata_next = pwdata_i;
          err_next   = setup_err;
          if (WAIT_CYCLES == 0) begin
            state_next   = ST_RESP;
            pready_next  = 1'b1;
            pslverr_next = setup_err;
            prdata_next  = (setup_err | pwrite_i) ? 32'd0 : read_mux(setup_idx);
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!psel_i) begin
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg <= 4'd1) begin
          state_next   = ST_RESP;
          cnt_next     = 4'd0;
          pready_next  = 1'b1;
          pslverr_next = err_reg;
          prdata_next  = (err_reg | write_reg) ? 32'd0 : read_mux(idx_reg);
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_RESP: begin
        if (!psel_i) begin
          state_next   = ST_IDLE;
          pready_next  = 1'b0;
          pslverr_next = 1'b0;
        end else if (penable_i) begin
          commit       = write_reg & ~err_reg;
          state_next   = ST_IDLE;
          pready_next  = 1'b0;
          pslverr_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched transfer and registered bus outputs
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 4'd0;
      idx_reg     <= 3'd0;
      write_reg   <= 1'b0;
      wdata_reg   <= 32'd0;
      err_reg     <= 1'b0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= 32'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      write_reg   <= write_next;
      wdata_reg   <= wdata_next;
      err_reg     <= err_next;
      pready_reg  <= pready_next;
      pslverr_reg <= pslverr_next;
      prdata_reg  <= prdata_next;
    end
  end

  // Per-register write enables for the committed write
  generate
    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_wen
      assign reg_wen[gi] = commit & (idx_reg == 3'(gi));
    end
  endgenerate

  // RW scratch registers update at the edge that ends the ready cycle
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NUM_RW; i++) regs_reg[i] <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (reg_wen[i]) regs_reg[i] <= wdata_reg;
      end
    end
  end

  // Committed-write counter, wraps naturally at 32 bits
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_count_reg <= 32'd0;
    end else if (commit) begin
      wr_count_reg <= wr_count_reg + 32'd1;
    end
  end

  assign prdata_o  = prdata_reg;
  assign pready_o  = pready_reg;
  assign pslverr_o = pslverr_reg;
  assign ctrl_o    = regs_reg[0];

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: one instance with no wait states,
// one with three. Expected responses are pushed to a scoreboard when a
// transfer is driven and popped when the completer raises pready.
module tb_apb_regfile_slave;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata0, prdata3, ctrl0, ctrl3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  // Reference model: index 0 = no-wait instance, 1 = three-wait instance
  logic [31:0] m_regs [2][6];
  logic [31:0] m_cnt  [2];

  always #5 pclk = ~pclk;

  apb_regfile_slave #(.WAIT_CYCLES(0), .ADDR_W(32), .ID_VALUE(ID)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel_i(psel0), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0), .ctrl_o(ctrl0)
  );

  apb_regfile_slave #(.WAIT_CYCLES(3), .ADDR_W(32), .ID_VALUE(ID)) u_dut3 (
    .pclk(pclk), .preset(preset), .psel_i(psel3), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata3), .pready_o(pready3), .pslverr_o(pslverr3), .ctrl_o(ctrl3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 6; r++) m_regs[d][r] = 32'd0;
      m_cnt[d] = 32'd0;
    end
  endtask

  // One complete transfer on instance `which`; leaves psel/penable high so
  // a following call runs back-to-back with no idle cycle
  task automatic xfer(input int which, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input string tag);
    exp_t e, got;
    int   idx, lat;
    logic rdy, serr;
    logic [31:0] rdat;
    idx   = int'(addr[4:2]);
    e.lat = (which == 0) ? 1 : 4;
    e.err = (addr[1:0] != 2'b00) || (addr[31:5] != 27'd0) || (wr && idx >= 6);
    if (e.err || wr)  e.data = 32'd0;
    else if (idx < 6) e.data = m_regs[which][idx];
    else if (idx == 6) e.data = m_cnt[which];
    else              e.data = ID;
    sb.push_back(e);

    @(negedge pclk);
    psel0 = (which == 0); psel3 = (which == 1);
    penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
    @(negedge pclk);
    penable = 1'b1;
    lat = 1;
    rdy = (which == 0) ? pready0 : pready3;
    while (!rdy && lat < 40) begin
      @(negedge pclk);
      lat++;
      rdy = (which == 0) ? pready0 : pready3;
    end
    serr = (which == 0) ? pslverr0 : pslverr3;
    rdat = (which == 0) ? prdata0 : prdata3;
    got = sb.pop_front();
    check($sformatf("%s latency", tag), lat, got.lat);
    check($sformatf("%s pslverr", tag), {31'd0, serr}, {31'd0, got.err});
    if (!wr) check($sformatf("%s prdata", tag), rdat, got.data);
    $display("xfer %-14s dut%0d %s addr=%h wdata=%h -> prdata=%h pslverr=%0b lat=%0d",
             tag, which, wr ? "WR" : "RD", addr, wdata, rdat, serr, lat);
    if (rdy && wr && !got.err) begin
      m_regs[which][idx] = wdata;
      m_cnt[which]       = m_cnt[which] + 32'd1;
    end
  endtask

  task automatic idle();
    @(negedge pclk);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic seen;
    preset = 1'b1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0;
    model_reset();
    repeat (2) @(negedge pclk);
    check("rst pready0",  {31'd0, pready0},  32'd0);
    check("rst pslverr0", {31'd0, pslverr0}, 32'd0);
    check("rst prdata0",  prdata0,           32'd0);
    check("rst ctrl0",    ctrl0,             32'd0);
    check("rst pready3",  {31'd0, pready3},  32'd0);
    check("rst ctrl3",    ctrl3,             32'd0);
    preset = 1'b0;

    // Basic write/read with no wait states
    xfer(0, 32'h04, 1'b1, 32'hDEAD_BEEF, "w0 04");
    xfer(0, 32'h04, 1'b0, 32'h0,         "r0 04");
    xfer(0, 32'h18, 1'b0, 32'h0,         "r0 cnt");
    idle();

    // Three wait states; ctrl_o follows one cycle after completion
    xfer(1, 32'h00, 1'b1, 32'h1234_5678, "w3 00");
    idle();
    check("ctrl3 after w", ctrl3, m_regs[1][0]);

    // Error decode
    xfer(0, 32'h1C, 1'b1, 32'h5555_AAAA, "w0 id err");
    xfer(0, 32'h1C, 1'b0, 32'h0,         "r0 id");
    xfer(0, 32'h02, 1'b0, 32'h0,         "r0 unalign");
    xfer(0, 32'h20, 1'b0, 32'h0,         "r0 range");
    xfer(0, 32'h18, 1'b0, 32'h0,         "r0 cnt2");
    idle();

    // Back-to-back on the waited instance
    xfer(1, 32'h18, 1'b1, 32'h0BAD_0BAD, "b2b w18");
    xfer(1, 32'h00, 1'b0, 32'h0,         "b2b r00");
    xfer(1, 32'h14, 1'b1, 32'hFACE_0014, "b2b w14");
    xfer(1, 32'h14, 1'b0, 32'h0,         "b2b r14");
    xfer(1, 32'h18, 1'b0, 32'h0,         "b2b cnt");
    idle();

    // Access phase without setup is ignored
    @(negedge pclk);
    psel0 = 1'b1; penable = 1'b1; paddr = 32'h04; pwrite = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      if (pready0) seen = 1'b1;
    end
    check("bare access", {31'd0, seen}, 32'd0);
    idle();

    // Abort during WAIT: no response, no write
    @(negedge pclk);
    psel3 = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1; pwdata = 32'hCAFE_F00D;
    @(negedge pclk);
    penable = 1'b1;
    seen = pready3;
    @(negedge pclk);
    if (pready3) seen = 1'b1;
    psel3 = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge pclk);
      if (pready3) seen = 1'b1;
    end
    check("abort pready", {31'd0, seen}, 32'd0);
    xfer(1, 32'h08, 1'b0, 32'h0, "abort r08");
    xfer(1, 32'h18, 1'b0, 32'h0, "abort cnt");
    idle();

    // WR_COUNT wrap
    @(negedge pclk);
    u_dut0.wr_count_reg = 32'hFFFF_FFFF;
    m_cnt[0] = 32'hFFFF_FFFF;
    xfer(0, 32'h10, 1'b1, 32'h0000_0010, "wrap w10");
    xfer(0, 32'h18, 1'b0, 32'h0,         "wrap cnt");
    idle();

    // Asynchronous reset in the middle of WAIT
    @(negedge pclk);
    psel3 = 1'b1; penable = 1'b0; paddr = 32'h00; pwrite = 1'b1; pwdata = 32'h7777_7777;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    #2 preset = 1'b1;
    #1;
    check("mid rst pready3",  {31'd0, pready3},  32'd0);
    check("mid rst pslverr3", {31'd0, pslverr3}, 32'd0);
    check("mid rst prdata3",  prdata3,           32'd0);
    check("mid rst ctrl3",    ctrl3,             32'd0);
    model_reset();
    @(negedge pclk);
    psel3 = 1'b0; penable = 1'b0;
    preset = 1'b0;
    xfer(1, 32'h00, 1'b0, 32'h0, "post rst r00");
    xfer(1, 32'h18, 1'b0, 32'h0, "post rst cnt");
    idle();

    repeat (2) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- APB3 completer (slave) that answers transfers issued by the team's APB masters, e.g. the adder master.
- Holds a small 32-bit register file: six read/write scratch registers, a read-only write counter and a read-only ID register.
- Inserts a parameterised number of wait states and flags illegal accesses with PSLVERR.
- Used as the standard bus-side responder in APB benches and as a control-register block in small subsystems.

Parameters:
- WAIT_CYCLES, 0: wait states inserted per transfer; legal range 0..15.
- ADDR_W, 32: width of paddr_i.
- ID_VALUE, 32'hA9B0_0001: constant returned by the ID register.

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- preset  in  1  asynchronous, active-high reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- paddr_i  in  ADDR_W  byte address.
- pwrite_i  in  1  1 = write, 0 = read.
- pwdata_i  in  32  write data.
- prdata_o  out  32  read data; valid while pready_o=1.
- pready_o  out  1  transfer completes in the current cycle.
- pslverr_o  out  1  error response; valid while pready_o=1.
- ctrl_o  out  32  live copy of register 0 (0x00).

Behaviour:
- Reset (preset=1, asynchronous):
  - pready_o=0, pslverr_o=0, prdata_o=0, ctrl_o=0.
  - All RW registers = 0, WR_COUNT = 0.
  - FSM = IDLE, wait counter = 0.
- Register map (offset from paddr_i[4:2]):
  - 0x00-0x14: RW scratch registers 0-5.
  - 0x18: WR_COUNT (RO). Counts successful writes; +1 per committed write; wraps 0xFFFF_FFFF -> 0.
  - 0x1C: ID (RO). Returns ID_VALUE.
- Error decode:
  - paddr_i[1:0] != 0 -> error.
  - Any of paddr_i[ADDR_W-1:5] != 0 -> error.
  - Write to 0x18 or 0x1C -> error.
  - Error response: pslverr_o=1, prdata_o=0, no register update, WR_COUNT unchanged.
- FSM states:
  - IDLE: on an edge with psel_i=1 and penable_i=0 (setup phase), decode and latch addr/write/wdata.
    - WAIT_CYCLES=0: go to RESP; pready_o<=1, pslverr_o and prdata_o loaded at the same edge.
    - WAIT_CYCLES>0: go to WAIT; counter<=WAIT_CYCLES.
  - WAIT: counter decrements each edge while psel_i=1. When counter==1: go to RESP and register pready_o/pslverr_o/prdata_o as above.
  - RESP: pready_o=1 for exactly one cycle.
    - If psel_i & penable_i: commit the write at that edge (when not an error), then pready_o<=0, pslverr_o<=0, go to IDLE.
- Timing:
  - pready_o, pslverr_o and prdata_o are all registered; no combinational path from inputs to outputs.
  - Access phase lasts WAIT_CYCLES+1 cycles, so the total transfer is WAIT_CYCLES+2 cycles.
- Read data:
  - Captured when pready_o rises and held after completion until the next response loads it.
  - Read of WR_COUNT returns its value before any write in the same transfer.
- Write commit:
  - The RW register updates at the edge ending the pready_o=1 cycle; ctrl_o follows from the next cycle.
  - WR_COUNT increments at the same edge.
- Back-to-back transfers:
  - A new setup phase is legal the cycle after completion and follows the same latency.
  - No transfer is lost.
- Abort:
  - psel_i=0 while in WAIT or RESP -> return to IDLE, pready_o<=0, no write, no count.
- Protocol violation:
  - penable_i=1 seen in IDLE without a preceding setup -> ignored; pready_o stays 0.
- Reset mid-transfer: immediate return to the reset state; the pending write is discarded.

Test Plan:
- Reset, then WAIT_CYCLES=0: write 0xDEAD_BEEF to 0x04, then read 0x04.
  - pready_o high in the first access cycle; read returns 0xDEAD_BEEF.
  - pslverr_o=0; WR_COUNT reads 1.
- WAIT_CYCLES=3: write 0x1234_5678 to 0x00.
  - pready_o rises exactly 3 cycles after access starts.
  - ctrl_o=0x1234_5678 one cycle after completion.
- Error cases:
  - Write to 0x1C -> pslverr_o=1, ID still 0xA9B0_0001.
  - Read 0x02 -> pslverr_o=1, prdata_o=0.
  - Read 0x20 -> pslverr_o=1.
  - WR_COUNT unchanged after all three.
- Back-to-back: write 0x18 / read 0x00 / write 0x14 with no idle cycles.
  - Each completes in WAIT_CYCLES+2 cycles with correct data.
  - WR_COUNT increments by 1 only (the 0x18 write errors).
- Abort and reset:
  - Drop psel_i during WAIT with a write to 0x08 -> 0x08 stays 0, pready_o never asserts.
  - Assert preset mid-WAIT -> all outputs 0 immediately.
- WR_COUNT wrap: force WR_COUNT to 0xFFFF_FFFF via a bench hierarchical deposit, then issue one write -> WR_COUNT reads 0.
